okand_host_link: RTL
====================

Name: okand_host_link

Overview:
- Host-side transaction adapter for the serial AND engine.
- Accepts a parallel operand pair over a valid/ready request port and serialises it onto pc_data/pc_valid as a 32-bit LSB-first frame.
- Deserialises the 16-bit fpga_data/fpga_valid response stream back into a parallel result.
- Returns the result, or a timeout flag, on a valid/ready response port.
- Sits directly upstream of the AND engine and also consumes its output. Used for on-board self-test and as the bridge for a parallel host interface.

Parameters:
- OP_WIDTH, 16: operand and result width. Must match the engine's 16-bit operands.
- TIMEOUT_CYCLES, 64: maximum pc_clk cycles allowed from the end of the sent frame to the completion of the response.

Ports:
- pc_clk  in  1  clock; all logic is on the rising edge.
- pc_rst  in  1  synchronous, active-high reset. Shared with the engine.
- req_valid  in  1  request operands valid.
- req_ready  out  1  adapter can accept a request.
- req_a  in  OP_WIDTH  operand 1.
- req_b  in  OP_WIDTH  operand 2.
- pc_data  out  1  serial operand bit to the engine.
- pc_valid  out  1  qualifies pc_data.
- fpga_data  in  1  serial result bit from the engine.
- fpga_valid  in  1  qualifies fpga_data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  OP_WIDTH  collected result.
- rsp_timeout  out  1  response incomplete; qualified by rsp_valid.
- busy  out  1  transaction in flight (any state other than IDLE).

Behaviour:
- **Reset** (pc_rst high at a clock edge):
  - state <= IDLE.
  - pc_valid, pc_data, rsp_valid, rsp_result, rsp_timeout, busy, and all counters are cleared to 0.
  - req_ready is 0 while pc_rst is high, and equals (state==IDLE) otherwise.
  - Reset mid-transaction aborts it with no response. pc_valid is 0 after that edge.
  - The engine has no frame marker, so the engine must be reset in the same cycle; pc_rst is shared for this reason.
- **States:** IDLE, SEND, WAIT, RECV, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid&&req_ready: load shift register {req_b, req_a} (32 bits), clear bit_cnt, go to SEND.
- **SEND:**
  - pc_valid and pc_data are registered.
  - The first bit appears in the cycle after acceptance. Frame is exactly 32 consecutive pc_valid=1 cycles, with no gaps.
  - Bit order: req_a[0..15], then req_b[0..15]. Shift right each cycle.
  - The cycle after the 32nd bit: pc_valid=0, pc_data=0, clear timer, clear res_cnt, go to WAIT.
- **WAIT:**
  - timer increments each cycle.
  - fpga_valid=1: rsp_result[0] <= fpga_data, res_cnt=1, go to RECV.
  - timer reaches TIMEOUT_CYCLES-1 with no fpga_valid: rsp_timeout <= 1, go to RESP.
- **RECV:**
  - The timer keeps running.
  - Each cycle with fpga_valid=1: rsp_result[res_cnt] <= fpga_data; res_cnt++.
  - Cycles with fpga_valid=0 are tolerated, with no capture.
  - Capture of bit 15: go to RESP with rsp_timeout=0.
  - Timeout before bit 15: go to RESP with rsp_timeout=1. rsp_result keeps the bits captured so far; uncaptured bits are 0.
- **RESP:**
  - rsp_valid=1. rsp_result and rsp_timeout are held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE; rsp_valid falls the next cycle.
  - rsp_ready in other states is ignored.
- **Stray input:** fpga_valid in IDLE, SEND or RESP is ignored and does not corrupt rsp_result.
- **Response clearing:** rsp_result and rsp_timeout clear to 0 on request acceptance.
- **Back-to-back transactions:** request acceptance is possible in the cycle after the RESP handshake. There is no overlap of frames.
- **Nominal latency with the engine:**
  - Acceptance to first pc_valid: 1 cycle.
  - Frame: 32 cycles.
  - Response: the engine's compute plus output delay, then 16 cycles.
  - Total must be well inside TIMEOUT_CYCLES at the default.

Test Plan:
- Reset release, then req_a=16'hFFFF, req_b=16'h00FF, with the engine model attached -> pc_valid high exactly 32 cycles; bits 0..15 all 1, bits 16..31 = 1×8 then 0×8; rsp_valid with rsp_result=16'h00FF, rsp_timeout=0.
- req_a=16'hA5A5, req_b=16'h0FF0 -> rsp_result=16'h05A0. Then hold rsp_ready=0 for 10 cycles while a second req_valid is pending -> result stable, req_ready=0, second request not accepted. Release rsp_ready -> second request is accepted the cycle after the handshake.
- No response (fpga_valid tied 0) -> rsp_valid with rsp_timeout=1 and rsp_result=0, exactly TIMEOUT_CYCLES cycles after the frame end.
- Response stream with 3-cycle gaps after bits 4 and 11, total within timeout -> correct result, no timeout. Same stream truncated after 9 bits -> rsp_timeout=1; rsp_result bits 0..8 match, bits 9..15 are 0.
- pc_rst asserted at frame bit 10 -> pc_valid=0 and busy=0 next cycle, no rsp_valid. A fresh request 16'h1234 & 16'hFF00 then yields 16'h1200.
- fpga_valid pulses injected during IDLE and SEND -> ignored; the following transaction returns the correct result.

Source files
------------

// File: rtl/okand_host_link.sv
// Host-side adapter for the serial AND engine: serialises {req_b, req_a} LSB-first
// onto pc_data/pc_valid and collects the 16-bit serial result into a parallel response.
module okand_host_link #(
    parameter int OP_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                pc_clk,
    input  logic                pc_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_WIDTH-1:0] req_a,
    input  logic [OP_WIDTH-1:0] req_b,
    output logic                pc_data,
    output logic                pc_valid,
    input  logic                fpga_data,
    input  logic                fpga_valid,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OP_WIDTH-1:0] rsp_result,
    output logic                rsp_timeout,
    output logic                busy
);
    localparam int FRAME_BITS = 2 * OP_WIDTH;
    localparam int BCW        = $clog2(FRAME_BITS);
    localparam int RCW        = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(FRAME_BITS - 1);
    localparam logic [RCW-1:0] RES_LAST   = RCW'(OP_WIDTH - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic [RCW-1:0]        res_cnt_r;
    logic [TW-1:0]         timer_r;
    logic                  pc_data_r;
    logic                  pc_valid_r;
    logic                  rsp_valid_r;
    logic                  rsp_timeout_r;
    logic                  busy_r;
    logic [OP_WIDTH-1:0]   rsp_result_r;
    logic                  req_ready_s;
    logic                  accept_s;
    logic                  timer_last_s;
    logic                  last_bit_s;

    // State register
    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a bit captured on the final timer cycle still counts
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bit_cnt_r == BIT_LAST) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT, ST_RECV: begin
                if (last_bit_s || timer_last_s) begin
                    state_nxt_s = ST_RESP;
                end else if (fpga_valid) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and qualifier decode
    always_comb begin
        req_ready_s = 1'b0;
        if (pc_rst) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = (state_r == ST_IDLE);
        end
        accept_s     = req_valid && req_ready_s;
        timer_last_s = (timer_r == TIMER_LAST);
        last_bit_s   = fpga_valid && (res_cnt_r == RES_LAST);
    end

    // Serialiser, deserialiser, timer and response registers
    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            shift_r       <= '0;
            bit_cnt_r     <= '0;
            res_cnt_r     <= '0;
            timer_r       <= '0;
            pc_data_r     <= 1'b0;
            pc_valid_r    <= 1'b0;
            rsp_result_r  <= '0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // Bit 0 goes out immediately; the rest shifts out of shift_r
                        shift_r       <= {req_b, req_a} >> 1;
                        pc_data_r     <= req_a[0];
                        pc_valid_r    <= 1'b1;
                        bit_cnt_r     <= '0;
                        rsp_result_r  <= '0;
                        rsp_timeout_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        pc_valid_r <= 1'b0;
                        pc_data_r  <= 1'b0;
                        timer_r    <= '0;
                        res_cnt_r  <= '0;
                    end else begin
                        pc_data_r <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                    end
                end
                ST_WAIT, ST_RECV: begin
                    timer_r <= timer_r + TW'(1);
                    if (fpga_valid) begin
                        rsp_result_r[res_cnt_r] <= fpga_data;
                        res_cnt_r               <= res_cnt_r + RCW'(1);
                    end
                    if (timer_last_s && !last_bit_s) begin
                        rsp_timeout_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    pc_valid_r <= 1'b0;
                end
                default: begin
                    pc_valid_r <= 1'b0;
                    pc_data_r  <= 1'b0;
                end
            endcase
        end
    end

    // Registered status outputs follow the next state
    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign req_ready   = req_ready_s;
    assign pc_data     = pc_data_r;
    assign pc_valid    = pc_valid_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_timeout = rsp_timeout_r;
    assign busy        = busy_r;

endmodule
